// File: rtl/op_cic_pkg.sv
// Shared constants and helpers for the CIC decimation chain (integrator and comb stages).
package op_cic_pkg;

  localparam int unsigned CIC_WIDTH = 19;
  localparam int unsigned CIC_ORDER = 3;
  localparam int unsigned CIC_DECIM = 64;

  // Bit growth of an ORDER-stage CIC at ratio DECIM; both integrator and comb size to this.
  localparam int unsigned CIC_WIDTH_REQ = CIC_ORDER * $clog2(CIC_DECIM) + 1;

  function automatic bit cic_width_ok(input int unsigned width, input int unsigned decim);
    return (width == CIC_ORDER * $clog2(decim) + 1);
  endfunction

  // PDM bit to two's-complement +1 / -1; caller sign-extends bit 1.
  function automatic logic [1:0] pdm_to_pm1(input logic b);
    return b ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/op_cic_integrator_stage.sv
// Single enable-gated wrap-around accumulator with asynchronous clear.
module op_cic_integrator_stage #(
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  // Modulo 2^WIDTH on purpose: the comb stage cancels the wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/op_cic_integrator_decimator.sv
// Three-stage CIC integrator plus decimate-by-DECIM sampler feeding the comb stage.
// Optional OP_CIC_SYNC_EN adds a sync input that realigns the decimation phase.
module op_cic_integrator_decimator
  import op_cic_pkg::*;
#(
  parameter int unsigned WIDTH = CIC_WIDTH,
  parameter int unsigned DECIM = CIC_DECIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_in,
  input  logic             pdm_en,
`ifdef OP_CIC_SYNC_EN
  input  logic             sync,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int unsigned CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  if (!cic_width_ok(WIDTH, DECIM)) begin : g_bad_width
    $error("op_cic_integrator_decimator: WIDTH must equal ORDER*log2(DECIM)+1");
  end

  logic [1:0]       x_pm1;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    x_pm1 = pdm_to_pm1(pdm_in);
    x     = {{(WIDTH-2){x_pm1[1]}}, x_pm1};
  end

  // Each stage adds the pre-edge value of the previous one, giving a registered cascade.
  op_cic_integrator_stage #(.WIDTH(WIDTH)) u_int1 (
    .clk (clk),
    .rst (rst),
    .en  (pdm_en),
    .din (x),
    .acc (i1)
  );

  op_cic_integrator_stage #(.WIDTH(WIDTH)) u_int2 (
    .clk (clk),
    .rst (rst),
    .en  (pdm_en),
    .din (i1),
    .acc (i2)
  );

  op_cic_integrator_stage #(.WIDTH(WIDTH)) u_int3 (
    .clk (clk),
    .rst (rst),
    .en  (pdm_en),
    .din (i2),
    .acc (i3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
`ifdef OP_CIC_SYNC_EN
      // sync owns the counter; a coincident enable is still integrated but emits nothing.
      if (sync) begin
        cnt <= '0;
      end else
`endif
      if (pdm_en) begin
        if (cnt == CNT_LAST) begin
          cnt       <= '0;
          out       <= i3;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_op_cic_integrator_decimator.sv
// Directed bench for op_cic_integrator_decimator (DECIM=64, WIDTH=19); OP_CIC_SYNC_EN adds the sync test.
module tb_op_cic_integrator_decimator;

  localparam int unsigned WIDTH = 19;
  localparam int unsigned DECIM = 64;

  logic             clk;
  logic             rst;
  logic             pdm_in;
  logic             pdm_en;
  logic             sync;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  int total;
  int bad;

  op_cic_integrator_decimator #(.WIDTH(WIDTH), .DECIM(DECIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .pdm_en    (pdm_en),
`ifdef OP_CIC_SYNC_EN
    .sync      (sync),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst    = 1'b1;
    pdm_en = 1'b0;
    pdm_in = 1'b0;
    sync   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Enables every gap-th cycle until out_valid or limit; reports cycles used and whether out held meanwhile.
  task automatic run_until_pulse(input int gap, input logic din, input int limit,
                                 output int cycles, output logic stable,
                                 output logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] held;
    held   = out;
    stable = 1'b1;
    cycles = 0;
    for (int c = 0; c < limit; c++) begin
      pdm_in = din;
      pdm_en = ((c % gap) == gap - 1);
      @(posedge clk);
      #1;
      cycles = c + 1;
      if (out_valid) break;
      if (out !== held) stable = 1'b0;
    end
    pdm_en = 1'b0;
    val    = out;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    pdm_en = 1'b0;
    pdm_in = 1'b0;
    sync   = 1'b0;
    #1;
    total++;
    if (out !== '0) begin
      bad++;
      $display("FAIL reset_out: got %0d want 0", out);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_const_ones;
    int cyc;
    logic st;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] exp_v [3];
    exp_v[0] = 19'd39711;
    exp_v[1] = 19'd333375;
    exp_v[2] = 19'd94559;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_until_pulse(1, 1'b1, 200, cyc, st, v);
      total++;
      if (cyc != 64) begin
        bad++;
        $display("FAIL ones_spacing[%0d]: got %0d cycles want 64", k, cyc);
      end
      total++;
      if (v !== exp_v[k]) begin
        bad++;
        $display("FAIL ones_value[%0d]: got %0d want %0d", k, v, exp_v[k]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out !== exp_v[2]) begin
      bad++;
      $display("FAIL ones_hold: got valid=%b out=%0d want valid=0 out=%0d", out_valid, out, exp_v[2]);
    end
  endtask

  task automatic test_const_zeros;
    int cyc;
    logic st;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] exp_v [2];
    exp_v[0] = 19'd484577;
    exp_v[1] = 19'd190913;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run_until_pulse(1, 1'b0, 200, cyc, st, v);
      total++;
      if (cyc != 64 || v !== exp_v[k]) begin
        bad++;
        $display("FAIL zeros_pulse[%0d]: got cycles=%0d out=%0d want cycles=64 out=%0d", k, cyc, v, exp_v[k]);
      end
    end
  endtask

  task automatic test_gapped;
    int cyc;
    logic st;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] exp_v [2];
    exp_v[0] = 19'd39711;
    exp_v[1] = 19'd333375;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run_until_pulse(3, 1'b1, 600, cyc, st, v);
      total++;
      if (cyc != 192) begin
        bad++;
        $display("FAIL gapped_spacing[%0d]: got %0d cycles want 192", k, cyc);
      end
      total++;
      if (v !== exp_v[k]) begin
        bad++;
        $display("FAIL gapped_value[%0d]: got %0d want %0d", k, v, exp_v[k]);
      end
      total++;
      if (st !== 1'b1) begin
        bad++;
        $display("FAIL gapped_stable[%0d]: got out changed between pulses want held", k);
      end
    end
  endtask

  // Alternating input through a reference 3-stage comb: DC content is zero, so comb output settles near 0.
  task automatic test_alternating;
    logic [WIDTH-1:0] z1, z2, z3, a, b, y;
    int n_out;
    z1 = '0;
    z2 = '0;
    z3 = '0;
    n_out = 0;
    do_reset();
    for (int n = 0; n < 4096; n++) begin
      pdm_in = (n % 2 == 0);
      pdm_en = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid) begin
        a  = out - z1;
        z1 = out;
        b  = a - z2;
        z2 = a;
        y  = b - z3;
        z3 = b;
        if (n_out >= 4) begin
          total++;
          if ($isunknown(out) || $signed(y) > 64 || $signed(y) < -64) begin
            bad++;
            $display("FAIL alt_comb[%0d]: got %0d want within +/-64", n_out, $signed(y));
          end
        end
        n_out++;
      end
    end
    pdm_en = 1'b0;
    total++;
    if (n_out != 64) begin
      bad++;
      $display("FAIL alt_count: got %0d outputs want 64", n_out);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic st;
    logic [WIDTH-1:0] v;
    do_reset();
    run_until_pulse(1, 1'b1, 200, cyc, st, v);
    for (int n = 0; n < 40; n++) begin
      pdm_in = 1'b1;
      pdm_en = 1'b1;
      @(posedge clk);
      #1;
    end
    pdm_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got out=%0d valid=%b want out=0 valid=0 (pre-reset out was %0d)", out, out_valid, v);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_until_pulse(1, 1'b1, 200, cyc, st, v);
    total++;
    if (cyc != 64 || v !== 19'd39711) begin
      bad++;
      $display("FAIL mid_reset_first: got cycles=%0d out=%0d want cycles=64 out=39711", cyc, v);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    logic prev;
    pulses = 0;
    prev   = 1'b0;
    do_reset();
    for (int n = 0; n < 320; n++) begin
      pdm_in = 1'b1;
      pdm_en = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        total++;
        if (prev) begin
          bad++;
          $display("FAIL b2b_consecutive: got out_valid high on two cycles at cycle %0d want isolated", n);
        end
      end
      prev = out_valid;
    end
    pdm_en = 1'b0;
    total++;
    if (pulses != 5) begin
      bad++;
      $display("FAIL b2b_count: got %0d pulses want 5", pulses);
    end
  endtask

`ifdef OP_CIC_SYNC_EN
  task automatic test_sync;
    int cyc;
    logic st;
    logic [WIDTH-1:0] v;
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int n = 0; n < 63; n++) begin
      pdm_in = 1'b1;
      pdm_en = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
    if (out_valid) seen = 1'b1;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL sync_suppress: got out_valid during sync period want none");
    end
    run_until_pulse(1, 1'b1, 200, cyc, st, v);
    total++;
    if (cyc != 64 || v !== 19'd333375) begin
      bad++;
      $display("FAIL sync_next: got cycles=%0d out=%0d want cycles=64 out=333375", cyc, v);
    end
  endtask
`endif

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    pdm_in = 1'b0;
    pdm_en = 1'b0;
    sync   = 1'b0;
    total  = 0;
    bad    = 0;
    test_reset();
    test_const_ones();
    test_const_zeros();
    test_gapped();
    test_alternating();
    test_reset_mid();
    test_back_to_back();
`ifdef OP_CIC_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_cic_integrator_decimator.md
Name: op_cic_integrator_decimator

Overview:
Upstream feeder of the 19-bit third-order comb (differentiator) stage in each mic channel's CIC decimation chain.
- Takes the 1-bit PDM stream from one microphone and runs it through three cascaded wrap-around integrators.
- Decimates by DECIM and hands one 19-bit sample per output period to the comb stage, with a single-cycle valid strobe.
- Runs entirely on the system clock; PDM samples are qualified by an enable strobe.

Parameters:
- WIDTH, 19, integrator/output width; must equal ORDER*log2(DECIM)+1.
- DECIM, 64, decimation ratio (number of pdm_en strobes per output sample); power of two, ≥2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- pdm_in, input, 1, PDM data bit; sampled only when pdm_en=1.
- pdm_en, input, 1, one-cycle strobe marking a valid PDM bit.
- sync, input, 1, decimation-phase realign strobe (present only with OP_CIC_SYNC_EN).
- out, output, WIDTH, decimated integrator sample fed to the comb stage.
- out_valid, output, 1, one-cycle pulse; out is new on that cycle and holds until the next pulse.

Behaviour:
- Reset (async, rst=1): i1, i2, i3, decimation counter cnt, out, and out_valid all go to 0 immediately. Reset mid-period discards the partial period. The first output after reset arrives after exactly DECIM enables.
- Input mapping: pdm_in=1 → x=+1; pdm_in=0 → x=−1 (x is sign-extended to WIDTH, two's complement).
- Integrators: registered cascade; each stage uses the pre-edge value of the previous stage. On a cycle with pdm_en=1:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
- No update occurs when pdm_en=0.
- Arithmetic: all adds are modulo 2^WIDTH and wrap. Saturation is forbidden because the downstream comb relies on wrap cancellation.
- Decimation counter (0..DECIM−1) advances only on pdm_en.
  - When pdm_en=1 and cnt==DECIM−1: cnt <= 0, out <= i3 (the pre-edge value), out_valid <= 1.
  - Otherwise out_valid <= 0 and out holds.
- Latency: out and out_valid become visible on the edge that consumes the DECIM-th enable of the period. The integration in that cycle also happens and is not lost.
- out_valid is never high on two consecutive cycles; the minimum spacing is DECIM cycles.
- Constant-input steady state through the downstream comb gives ±DECIM^3. +2^18 is not representable in 19-bit signed and wraps to −262144; this is accepted system behaviour, documented here, and requires no handling in this block.
- pdm_en held high continuously is legal: one output every DECIM cycles.

Optional Feature:
OP_CIC_SYNC_EN
- Defined: the sync port exists. sync=1 forces cnt <= 0 on that edge without touching the integrators, so the output phase is aligned to the frame (lr_clk-derived) strobe.
  - If sync and pdm_en coincide, the enable's sample is still integrated, but sync wins on cnt: the counter loads 0 and no output is emitted.
  - The next out_valid follows exactly DECIM enables after the sync cycle.
- Undefined: there is no sync port, and cnt free-runs from reset.

Decomposition:
- Shared package op_cic_pkg holds:
  - CIC_WIDTH=19, CIC_ORDER=3, CIC_DECIM=64.
  - The PDM-to-±1 mapping function.
  - The width-check constant, so that the integrator block and the comb stage use the same widths.
- One natural sub-module: op_cic_integrator_stage. It is a single enable-gated WIDTH-bit wrap accumulator (acc <= acc + din on en, async clear) and is instantiated three times in a chain.

Test Plan:
- Constant ones: pdm_in=1, pdm_en every cycle, DECIM=64.
  - First out_valid on the 64th enable, with out=39711 (63·62·61/6).
  - Second out_valid exactly 64 cycles later.
- Constant zeros: same stimulus with pdm_in=0 → first out=524288−39711=484577 (i.e. −39711).
- Gapped enables: pdm_en every 3rd cycle, ones.
  - out_valid spacing is 192 cycles, values identical to the gap-free run.
  - out is stable between pulses.
- Alternating 1/0 for 4096 enables with the downstream comb attached → comb output is within ±DECIM of 0 after settling (after the 4th output); the integrators wrap without any X or saturation.
- Reset mid-period: assert rst asynchronously after 40 enables.
  - out=0 and out_valid=0 immediately.
  - After release, the first pulse comes after 64 enables with out=39711 for ones input.
- With OP_CIC_SYNC_EN: pulse sync coincident with the 64th enable → no out_valid on that edge; the next pulse is 64 enables later. Integrator values continue uninterrupted, and match the no-sync model shifted by one period.
